// File: rtl/stream_max_reduce_if.sv
// Stream interface for stream_max_reduce: a masked multi-lane input beat stream
// on one side and a (max, beat count) result per vector on the other.
interface stream_max_reduce_if #(
   parameter int DATAWIDTH = 16,
   parameter int LANES     = 4,
   parameter int CNTW      = 16
) ();
   logic                       in_valid;
   logic                       in_ready;
   logic [LANES*DATAWIDTH-1:0] in_data;
   logic [LANES-1:0]           in_mask;
   logic                       in_last;
   logic                       out_valid;
   logic                       out_ready;
   logic [DATAWIDTH-1:0]       out_max;
   logic [CNTW-1:0]            out_count;

   modport master (
      output in_valid, in_data, in_mask, in_last, out_ready,
      input  in_ready, out_valid, out_max, out_count
   );

   modport slave (
      input  in_valid, in_data, in_mask, in_last, out_ready,
      output in_ready, out_valid, out_max, out_count
   );
endinterface

// File: rtl/stream_max_reduce.sv
// Pipelined running-max reducer: per-beat registered compare tree over LANES
// floats, followed by an accumulate stage that emits max and beat count per vector.
module stream_max_reduce #(
   parameter int DATAWIDTH = 16,
   parameter int EXPONENT  = 5,
   parameter int MANTISSA  = 10,
   parameter int LANES     = 4,
   parameter int CNTW      = 16
) (
   input logic              clk,
   input logic              reset_n,
   stream_max_reduce_if.slave io
);
   localparam int LVL   = $clog2(LANES);
   localparam int NODES = 2*LANES - 1;
   localparam logic [DATAWIDTH-1:0] NEG_INF = {1'b1, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};

   // Map sign-magnitude float to an unsigned ordering key; both zeros share one key.
   function automatic logic [DATAWIDTH-1:0] okey(input logic [DATAWIDTH-1:0] v);
      if (v[DATAWIDTH-2:0] == '0)
         return {1'b1, {(DATAWIDTH-1){1'b0}}};
      else if (v[DATAWIDTH-1])
         return {1'b0, ~v[DATAWIDTH-2:0]};
      else
         return {1'b1, v[DATAWIDTH-2:0]};
   endfunction

   // Operand a wins ties.
   function automatic logic [DATAWIDTH-1:0] pick(input logic [DATAWIDTH-1:0] a,
                                                 input logic [DATAWIDTH-1:0] b);
      return (okey(b) > okey(a)) ? b : a;
   endfunction

   // Heap-ordered tree: node 0 is the root, lane i sits at node LANES-1+i,
   // children of n are 2n+1 (lower lanes) and 2n+2.
   logic [DATAWIDTH-1:0] node [NODES];
   logic [LVL:0]         vld;
   logic [LVL:0]         lst;

   logic [DATAWIDTH-1:0] acc;
   logic [CNTW-1:0]      cnt;
   logic [DATAWIDTH-1:0] out_max_q;
   logic [CNTW-1:0]      out_count_q;
   logic                 out_valid_q;

   logic                 adv;
   logic [DATAWIDTH-1:0] win;
   logic [CNTW-1:0]      cnt_inc;

   assign adv          = !(out_valid_q && !io.out_ready);
   assign io.in_ready  = adv;
   assign io.out_valid = out_valid_q;
   assign io.out_max   = out_max_q;
   assign io.out_count = out_count_q;

   assign win     = pick(acc, node[0]);
   assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NODES; i++) node[i] <= '0;
         vld         <= '0;
         lst         <= '0;
         acc         <= NEG_INF;
         cnt         <= '0;
         out_max_q   <= '0;
         out_count_q <= '0;
         out_valid_q <= 1'b0;
      end else if (adv) begin
         vld <= {vld[LVL-1:0], io.in_valid};
         lst <= {lst[LVL-1:0], io.in_valid && io.in_last};
         for (int i = 0; i < LANES; i++)
            node[LANES-1+i] <= io.in_mask[i] ? io.in_data[i*DATAWIDTH +: DATAWIDTH] : NEG_INF;
         for (int n = 0; n < LANES-1; n++)
            node[n] <= pick(node[2*n+1], node[2*n+2]);

         if (out_valid_q && io.out_ready) out_valid_q <= 1'b0;

         if (vld[LVL]) begin
            if (lst[LVL]) begin
               out_max_q   <= win;
               out_count_q <= cnt_inc;
               out_valid_q <= 1'b1;
               acc         <= NEG_INF;
               cnt         <= '0;
            end else begin
               acc <= win;
               cnt <= cnt_inc;
            end
         end
      end
   end
endmodule

// File: tb/tb_stream_max_reduce.sv
// Directed bench for stream_max_reduce: hand-computed expected results are queued
// at issue time and checked by an independent output monitor.
module tb_stream_max_reduce;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   stream_max_reduce_if #(.DATAWIDTH(16), .LANES(4), .CNTW(16)) sif ();

   stream_max_reduce #(
      .DATAWIDTH(16), .EXPONENT(5), .MANTISSA(10), .LANES(4), .CNTW(16)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .io      (sif)
   );

   typedef struct packed {
      logic [15:0] mx;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   function automatic logic [63:0] pk(input logic [15:0] l0, input logic [15:0] l1,
                                      input logic [15:0] l2, input logic [15:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   // Output monitor / scoreboard
   always @(negedge clk) begin
      if (reset_n && sif.out_valid && sif.out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got max %h count %0d want none",
                     sif.out_max, sif.out_count);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_max", {16'h0, sif.out_max}, {16'h0, e.mx});
            chk("out_count", {16'h0, sif.out_count}, {16'h0, e.cnt});
         end
      end
   end

   task automatic send(input logic [63:0] d, input logic [3:0] m, input logic l);
      int n;
      n = 0;
      @(negedge clk);
      sif.in_valid = 1'b1;
      sif.in_data  = d;
      sif.in_mask  = m;
      sif.in_last  = l;
      while (!sif.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!sif.in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready got 0 want 1");
      end
      @(posedge clk);
      #1;
      sif.in_valid = 1'b0;
      sif.in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_out_valid(input string name);
      int n;
      n = 0;
      while (!sif.out_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk(name, {31'h0, sif.out_valid}, 32'h1);
   endtask

   initial begin
      int lat;
      sif.in_valid  = 1'b0;
      sif.in_data   = '0;
      sif.in_mask   = '0;
      sif.in_last   = 1'b0;
      sif.out_ready = 1'b1;
      #1;
      chk("rst_out_valid", {31'h0, sif.out_valid}, 32'h0);
      chk("rst_out_max", {16'h0, sif.out_max}, 32'h0);
      chk("rst_out_count", {16'h0, sif.out_count}, 32'h0);
      chk("rst_in_ready", {31'h0, sif.in_ready}, 32'h1);
      #20;
      @(negedge clk);
      reset_n = 1'b1;

      // Single beat with latency measurement
      exp_q.push_back('{16'h4000, 16'd1});
      send(pk(16'h3C00, 16'h4000, 16'hBC00, 16'h3800), 4'b1111, 1'b1);
      lat = 1;
      while (!sif.out_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", lat, 32'd4);
      idle(3);

      // Three-beat vector with bubbles, then a single-beat vector
      exp_q.push_back('{16'h4200, 16'd3});
      send(pk(16'h3C00, 16'h3800, 16'h0000, 16'hBC00), 4'b1111, 1'b0);
      idle(2);
      send(pk(16'h4000, 16'h4200, 16'h3C00, 16'hC200), 4'b1111, 1'b0);
      idle(3);
      send(pk(16'h4000, 16'h3800, 16'hBC00, 16'h0000), 4'b1111, 1'b1);
      exp_q.push_back('{16'hBC00, 16'd1});
      send(pk(16'hBC00, 16'hBC00, 16'hBC00, 16'hBC00), 4'b1111, 1'b1);

      // Masking
      exp_q.push_back('{16'h3C00, 16'd1});
      send(pk(16'h4200, 16'h3800, 16'hC000, 16'h3C00), 4'b1110, 1'b1);
      exp_q.push_back('{16'hFC00, 16'd1});
      send(pk(16'h4200, 16'h3800, 16'hC000, 16'h3C00), 4'b0000, 1'b1);

      // Signed zeros: lane tie in the tree, then accumulator tie
      exp_q.push_back('{16'h8000, 16'd1});
      send(pk(16'h8000, 16'h0000, 16'h8000, 16'h0000), 4'b1111, 1'b1);
      exp_q.push_back('{16'h0000, 16'd2});
      send(pk(16'h0000, 16'h0000, 16'h0000, 16'h0000), 4'b1111, 1'b0);
      send(pk(16'h8000, 16'h8000, 16'h8000, 16'h8000), 4'b1111, 1'b1);
      idle(8);

      // Backpressure: result A stalls while vector B is in flight
      sif.out_ready = 1'b0;
      exp_q.push_back('{16'h3800, 16'd1});
      send(pk(16'h3400, 16'h3000, 16'h3800, 16'h2C00), 4'b1111, 1'b1);
      exp_q.push_back('{16'h4400, 16'd2});
      send(pk(16'h4400, 16'h4000, 16'h3C00, 16'h3800), 4'b1111, 1'b0);
      send(pk(16'h4200, 16'h4600, 16'h4100, 16'h4000), 4'b1101, 1'b1);
      wait_out_valid("bp_out_valid");
      @(negedge clk);
      sif.in_valid = 1'b1;
      sif.in_data  = pk(16'h7000, 16'h7000, 16'h7000, 16'h7000);
      sif.in_mask  = 4'b1111;
      sif.in_last  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_in_ready", {31'h0, sif.in_ready}, 32'h0);
         chk("bp_hold_max", {16'h0, sif.out_max}, 32'h3800);
      end
      sif.in_valid = 1'b0;
      sif.in_last  = 1'b0;
      sif.out_ready = 1'b1;
      idle(10);
      chk("bp_drained", exp_q.size(), 32'd0);

      // Async reset mid-vector with a pending result
      sif.out_ready = 1'b0;
      send(pk(16'h4000, 16'h4000, 16'h4000, 16'h4000), 4'b1111, 1'b1);
      send(pk(16'h4200, 16'h4200, 16'h4200, 16'h4200), 4'b1111, 1'b0);
      send(pk(16'h4200, 16'h4200, 16'h4200, 16'h4200), 4'b1111, 1'b0);
      wait_out_valid("pre_rst_out_valid");
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", {31'h0, sif.out_valid}, 32'h0);
      chk("mid_rst_out_max", {16'h0, sif.out_max}, 32'h0);
      chk("mid_rst_out_count", {16'h0, sif.out_count}, 32'h0);
      idle(2);
      reset_n = 1'b1;
      sif.out_ready = 1'b1;
      exp_q.push_back('{16'h3800, 16'd1});
      send(pk(16'h3800, 16'h3800, 16'h3800, 16'h3800), 4'b1111, 1'b1);
      idle(12);
      chk("final_drained", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
